// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
package adder_pkg;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit split_ok(input int width, input int stages);
        return (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Purely combinational W-bit ripple of full-adder cells; cmsb is the carry into the MSB.
module rca_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic carry;

    always_comb begin
        s     = '0;
        cmsb  = cin;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            cmsb  = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/adder_pipe_rca.sv
// Pipelined ripple-carry add/subtract with valid/ready; one CHUNK ripples per stage.
// Define ADDER_PIPE_OVF_EN to add the signed-overflow output out_ovf.
module adder_pipe_rca
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("adder_pipe_rca: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             vld_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];
`ifdef ADDER_PIPE_OVF_EN
    logic             ov_p  [STAGES];
`endif

    // One global advance keeps every stage in lock-step; bubbles are not collapsed.
    assign adv     = ~vld_p[STAGES-1] | out_ready;
    assign in_ready = adv;
    assign b_eff   = (in_sub == ADD_OP) ? in_b : ~in_b;
    assign cin_eff = (in_sub == SUB_OP) ? 1'b1 : in_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, s_in, s_nx;
        logic             c_in, v_in;
        logic [CHUNK-1:0] cs;
        logic             co;
`ifdef ADDER_PIPE_OVF_EN
        logic             cm;
`else
        logic             unused_cmsb;
`endif

        if (k == 0) begin : g_first
            assign a_in = in_a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = cin_eff;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = a_p[k-1];
            assign b_in = b_p[k-1];
            assign s_in = s_p[k-1];
            assign c_in = c_p[k-1];
            assign v_in = vld_p[k-1];
        end

        rca_chunk #(.W(CHUNK)) u_chunk (
            .a    (a_in[k*CHUNK +: CHUNK]),
            .b    (b_in[k*CHUNK +: CHUNK]),
            .cin  (c_in),
            .s    (cs),
            .cout (co),
`ifdef ADDER_PIPE_OVF_EN
            .cmsb (cm)
`else
            .cmsb (unused_cmsb)
`endif
        );

        // Completed lower chunks ride along so all chunks of an op emerge together.
        always_comb begin
            s_nx = s_in;
            s_nx[k*CHUNK +: CHUNK] = cs;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p[k] <= 1'b0;
            end else if (adv) begin
                vld_p[k] <= v_in;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                a_p[k] <= a_in;
                b_p[k] <= b_in;
                s_p[k] <= s_nx;
                c_p[k] <= co;
`ifdef ADDER_PIPE_OVF_EN
                ov_p[k] <= co ^ cm;
`endif
            end
        end
    end

    // Data registers are not reset; gating by valid gives the zero reset view.
    assign out_valid = vld_p[STAGES-1];
    assign out_sum   = out_valid ? s_p[STAGES-1] : '0;
    assign out_cout  = out_valid & c_p[STAGES-1];
`ifdef ADDER_PIPE_OVF_EN
    assign out_ovf   = out_valid & ov_p[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe_rca.sv
// Self-checking bench for adder_pipe_rca: directed steps plus randomized traffic against an arithmetic model.
module tb_adder_pipe_rca;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam longint SMAX = (longint'(1) <<< (WIDTH-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (WIDTH-1));

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_cin, in_sub;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid, out_ready, out_cout;
    logic [WIDTH-1:0] out_sum;
`ifdef ADDER_PIPE_OVF_EN
    logic             out_ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             last_in_fire = 1'b0;
    logic             hold_chk = 1'b0;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;

    adder_pipe_rca #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [WIDTH:0] w;
        longint       sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            w      = {1'b0, a} - {1'b0, b};
            e.cout = ~w[WIDTH];
            r      = sa - sb;
        end else begin
            w      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            e.cout = w[WIDTH];
            r      = sa + sb + longint'(cin);
        end
        e.sum = w[WIDTH-1:0];
        e.ovf = (r > SMAX) || (r < SMIN);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score outputs, record accepted inputs.
    task automatic cyc();
        exp_t e;
        #3;
        if (hold_chk) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_sum", 64'(out_sum), 64'(held_sum));
            chk("stall_cout", 64'(out_cout), 64'(held_cout));
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            hold_chk  = 1'b1;
            held_sum  = out_sum;
            held_cout = out_cout;
        end else begin
            hold_chk = 1'b0;
        end
        if (out_valid && out_ready) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_out observed=%0h expected=none", out_sum);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sum", 64'(out_sum), 64'(e.sum));
                chk("cout", 64'(out_cout), 64'(e.cout));
`ifdef ADDER_PIPE_OVF_EN
                chk("ovf", 64'(out_ovf), 64'(e.ovf));
`endif
            end
        end
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) q.push_back(model(in_a, in_b, in_cin, in_sub));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        int n;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_in_fire && n < 50);
        chk("send_accept", 64'(last_in_fire), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n, sent, cn;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency of a single op with no stall
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h0000_0001; in_b = 32'h0000_0002; in_cin = 1'b0; in_sub = 1'b0;
        cyc();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < STAGES + 10) begin
            cyc();
            n++;
        end
        chk("latency", 64'(n), 64'(STAGES));
        drain();

        // Full-width carry ripple and subtract with cin ignored
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();

        // Back-to-back stream of 8 with a 3-cycle output stall mid-stream
        sent = 0; cn = 0;
        while (sent < 8 && cn < 100) begin
            in_valid  = 1'b1;
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
            out_ready = !(cn >= 4 && cn < 7);
            cyc();
            if (last_in_fire) sent++;
            cn++;
        end
        chk("stream_sent", 64'(sent), 64'd8);
        drain();

        // Reset with ops in flight
        send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        send(32'h0000_3333, 32'h0000_4444, 1'b1, 1'b0);
        send(32'h0000_5555, 32'h0000_6666, 1'b0, 1'b1);
        out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        hold_chk = 1'b0;
        q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sum", 64'(out_sum), 64'd0);
        chk("midrst_out_cout", 64'(out_cout), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < STAGES + 3; i++) begin
            chk("no_stale_valid", 64'(out_valid), 64'd0);
            cyc();
        end

        // Randomized traffic with random backpressure and corner operands
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            case ($urandom_range(5))
                0:       in_a = '0;
                1:       in_a = '1;
                2:       in_a = {1'b1, {(WIDTH-1){1'b0}}};
                default: in_a = $urandom;
            endcase
            case ($urandom_range(5))
                0:       in_b = '0;
                1:       in_b = '1;
                2:       in_b = {1'b0, {(WIDTH-1){1'b1}}};
                default: in_b = $urandom;
            endcase
            in_cin = 1'($urandom);
            in_sub = 1'($urandom);
            cyc();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
